// File: rtl/bus_arbiter_ctrl_if.sv
// Request/grant bundle between the serial-bus masters and the round-robin arbiter.
// master_mp is the requester side, slave_mp is the arbiter side.
interface bus_arbiter_ctrl_if #(
  parameter int NO_MASTERS = 3,
  parameter int NO_SLAVES  = 5,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
);
  logic [S_ID_WIDTH-1:0] slave_id [NO_MASTERS];
  logic [NO_MASTERS-1:0] done;
  logic [NO_MASTERS-1:0] grant;
  logic [M_ID_WIDTH-1:0] master;
  logic [S_ID_WIDTH-1:0] slave;
  logic                  bus_busy;
  logic                  timeout;

  modport master_mp (
    output slave_id, done,
    input  grant, master, slave, bus_busy, timeout
  );

  modport slave_mp (
    input  slave_id, done,
    output grant, master, slave, bus_busy, timeout
  );
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// Round-robin serial-bus arbiter: grants one master at a time, holds until done,
// request drop or timeout, then inserts a release cycle before re-arbitrating.
module bus_arbiter_ctrl #(
  parameter int NO_MASTERS     = 3,
  parameter int NO_SLAVES      = 5,
  parameter int S_ID_WIDTH     = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH     = $clog2(NO_MASTERS),
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  bus_arbiter_ctrl_if.slave_mp bus
);
  localparam int unsigned NM = NO_MASTERS;
  localparam int          CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [M_ID_WIDTH-1:0] LAST_M = M_ID_WIDTH'(NO_MASTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [NO_MASTERS-1:0]  grant_q, grant_d;
  logic [M_ID_WIDTH-1:0]  master_q, master_d;
  logic [S_ID_WIDTH-1:0]  slave_q, slave_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [CW-1:0]          count_q, count_d;
  logic [M_ID_WIDTH-1:0]  rr_q, rr_d;

  logic                   found;
  logic [M_ID_WIDTH-1:0]  winner;
  logic [M_ID_WIDTH-1:0]  idx;
  logic                   rel;
  logic                   to_hit;

  // First requester at or after rr_q, wrapping around the master list.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx = M_ID_WIDTH'((32'(rr_q) + k) % NM);
      if (!found && bus.slave_id[idx] != '0) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign rel    = bus.done[master_q] || (bus.slave_id[master_q] == '0);
  assign to_hit = (TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      master_q  <= '0;
      slave_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      master_q  <= master_d;
      slave_q   <= slave_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (found) state_d = S_BUSY;
      S_BUSY:    if (rel || to_hit) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Release takes priority over timeout, so the pulse only fires on a forced revoke.
  always_comb begin
    grant_d   = grant_q;
    master_d  = master_q;
    slave_d   = slave_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    count_d   = count_q;
    rr_d      = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          master_d        = winner;
          slave_d         = bus.slave_id[winner];
          busy_d          = 1'b1;
          count_d         = '0;
        end
      end
      S_BUSY: begin
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        if (rel || to_hit) begin
          grant_d   = '0;
          slave_d   = '0;
          busy_d    = 1'b0;
          timeout_d = !rel;
          rr_d      = (master_q == LAST_M) ? '0 : master_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.master   = master_q;
  assign bus.slave    = slave_q;
  assign bus.bus_busy = busy_q;
  assign bus.timeout  = timeout_q;
endmodule
